// File: rtl/iso15693_pkg.sv
// Shared constants, state type and helpers for the ISO 15693 reader-to-tag frame sequencer.
// Optional build macro: ISO15693_1OF256_EN (adds the 1-of-256 SOF pattern use).
package iso15693_pkg;

    localparam int HALF_SLOT_DEF = 128;

    // Pulse patterns, MSB sent first, a 1 means carrier off for that half-slot
    localparam logic [7:0] SOF_1OF4   = 8'b1000_0100;
    localparam logic [7:0] SOF_1OF256 = 8'b1000_0001;
    localparam logic [3:0] EOF_PAT    = 4'b0010;
    localparam logic [3:0][7:0] SYM_PAT = {8'b0000_0001, 8'b0000_0100,
                                           8'b0001_0000, 8'b0100_0000};

    typedef enum logic [1:0] {IDLE, SOF, DATA, EOF} txState_t;

    function automatic logic patBit8(input logic [7:0] pat, input logic [2:0] idx);
        logic [2:0] bitIdx;
        bitIdx = 3'd7 - idx;
        return pat[bitIdx];
    endfunction

endpackage

// File: rtl/iso15693_tx_seq_if.sv
// ARM-side byte handshake plus modulation/status outputs of the ISO 15693 transmit sequencer.
// Optional build macro: ISO15693_1OF256_EN (adds mode256).
interface iso15693_tx_seq_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic       mod_dout;
    logic       busy;
    logic       underrun;
`ifdef ISO15693_1OF256_EN
    logic       mode256;

    modport master (output tx_data, tx_valid, tx_last, mode256,
                    input  tx_ready, mod_dout, busy, underrun);
    modport slave  (input  tx_data, tx_valid, tx_last, mode256,
                    output tx_ready, mod_dout, busy, underrun);
`else
    modport master (output tx_data, tx_valid, tx_last,
                    input  tx_ready, mod_dout, busy, underrun);
    modport slave  (input  tx_data, tx_valid, tx_last,
                    output tx_ready, mod_dout, busy, underrun);
`endif
endinterface

// File: rtl/iso15693_slot_timer.sv
// Half-slot cycle counter and slot index, restarted on the frame-start accept edge.
// Optional build macro: ISO15693_1OF256_EN (the parent widens SLOT_W to 9).
module iso15693_slot_timer #(
    parameter int HALF_SLOT = 128,
    parameter int CNT_W     = 7,
    parameter int SLOT_W    = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_run,
    input  logic              i_wrap,
    output logic              o_tick,
    output logic [SLOT_W-1:0] o_slot
);

    logic [CNT_W-1:0]  r_cnt;
    logic [SLOT_W-1:0] r_slot;
    logic              w_cntEnd;

    assign w_cntEnd = (r_cnt == CNT_W'(HALF_SLOT - 1));
    assign o_tick   = i_run && w_cntEnd;
    assign o_slot   = r_slot;

    // i_wrap returns the index to 0 at the end of the current pattern
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (i_run) begin
            if (w_cntEnd) begin
                r_cnt  <= '0;
                r_slot <= i_wrap ? '0 : r_slot + SLOT_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/iso15693_tx_seq.sv
// ISO 15693 reader-to-tag frame sequencer: SOF, 1-of-4 pulse-position data, EOF on mod_dout.
// Optional build macro: ISO15693_1OF256_EN (adds mode256 and 1-of-256 coding, 9-bit slot index).
module iso15693_tx_seq
    import iso15693_pkg::*;
#(
    parameter int HALF_SLOT = HALF_SLOT_DEF,
    parameter int CNT_W     = 7
) (
    input  logic             ck_1356meg,
    input  logic             rst_n,
    iso15693_tx_seq_if.slave bus
);

`ifdef ISO15693_1OF256_EN
    localparam int SLOT_W = 9;
`else
    localparam int SLOT_W = 3;
`endif

    txState_t    r_state;
    logic        r_modDout;
    logic        r_busy;
    logic        r_underrun;
    logic [7:0]  r_hold;
    logic        r_holdLast;
    logic        r_holdFull;
    logic [7:0]  r_shift;
    logic        r_curLast;
    logic        r_lastSeen;
    logic [1:0]  r_symCnt;
`ifdef ISO15693_1OF256_EN
    logic        r_mode256;
`endif

    logic              w_ready;
    logic              w_accept;
    logic              w_start;
    logic              w_run;
    logic              w_tick;
    logic              w_patEnd;
    logic              w_byteEnd;
    logic              w_bypass;
    logic [SLOT_W-1:0] w_slot;
    logic [SLOT_W-1:0] w_nextSlot;
    logic [7:0]        w_sofPat;
    logic [7:0]        w_loadByte;
    logic              w_loadLast;
    logic              w_curPulse;
    logic              w_nextSymPulse;
    logic              w_loadPulse;

    assign w_ready    = !r_holdFull && !r_lastSeen;
    assign w_accept   = bus.tx_valid && w_ready;
    assign w_start    = w_accept && (r_state == IDLE);
    assign w_run      = (r_state != IDLE);
    assign w_nextSlot = w_slot + SLOT_W'(1);
    assign w_loadByte = r_holdFull ? r_hold : bus.tx_data;
    assign w_loadLast = r_holdFull ? r_holdLast : bus.tx_last;

    // A byte arriving on the very edge its predecessor ends goes straight to the shifter
    assign w_bypass = (r_state == DATA) && w_tick && w_patEnd && w_byteEnd &&
                      !r_curLast && !r_holdFull && w_accept;

    assign bus.tx_ready = w_ready;
    assign bus.mod_dout = r_modDout;
    assign bus.busy     = r_busy;
    assign bus.underrun = r_underrun;

    iso15693_slot_timer #(
        .HALF_SLOT (HALF_SLOT),
        .CNT_W     (CNT_W),
        .SLOT_W    (SLOT_W)
    ) u_timer (
        .i_clk   (ck_1356meg),
        .i_rst_n (rst_n),
        .i_start (w_start),
        .i_run   (w_run),
        .i_wrap  (w_patEnd),
        .o_tick  (w_tick),
        .o_slot  (w_slot)
    );

    always_comb begin
        w_sofPat       = SOF_1OF4;
        w_byteEnd      = (r_symCnt == 2'd3);
        w_curPulse     = patBit8(SYM_PAT[r_shift[1:0]], w_nextSlot[2:0]);
        w_nextSymPulse = patBit8(SYM_PAT[r_shift[3:2]], 3'd0);
        w_loadPulse    = patBit8(SYM_PAT[w_loadByte[1:0]], 3'd0);
        w_patEnd       = 1'b0;
        case (r_state)
            SOF:     w_patEnd = (w_slot == SLOT_W'(7));
            DATA:    w_patEnd = (w_slot == SLOT_W'(7));
            EOF:     w_patEnd = (w_slot == SLOT_W'(3));
            default: w_patEnd = 1'b0;
        endcase
`ifdef ISO15693_1OF256_EN
        // One 512-half-slot symbol per byte, pulse in half-slot 2k+1
        if (r_mode256) begin
            w_sofPat       = SOF_1OF256;
            w_byteEnd      = 1'b1;
            w_curPulse     = (w_nextSlot == {r_shift, 1'b1});
            w_nextSymPulse = 1'b0;
            w_loadPulse    = 1'b0;
            if (r_state == DATA) begin
                w_patEnd = (w_slot == SLOT_W'(511));
            end
        end
`endif
    end

    // mod_dout is computed one edge ahead so it changes exactly on the half-slot boundary
    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_modDout  <= 1'b1;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
            r_hold     <= '0;
            r_holdLast <= 1'b0;
            r_holdFull <= 1'b0;
            r_shift    <= '0;
            r_curLast  <= 1'b0;
            r_lastSeen <= 1'b0;
            r_symCnt   <= '0;
`ifdef ISO15693_1OF256_EN
            r_mode256  <= 1'b0;
`endif
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state   <= SOF;
                        r_busy    <= 1'b1;
                        r_modDout <= 1'b0;
`ifdef ISO15693_1OF256_EN
                        r_mode256 <= bus.mode256;
`endif
                    end
                end
                SOF: begin
                    if (w_tick) begin
                        if (w_patEnd) begin
                            r_state    <= DATA;
                            r_shift    <= w_loadByte;
                            r_curLast  <= w_loadLast;
                            r_holdFull <= 1'b0;
                            r_symCnt   <= '0;
                            r_modDout  <= !w_loadPulse;
                        end else begin
                            r_modDout <= !patBit8(w_sofPat, w_nextSlot[2:0]);
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (!w_patEnd) begin
                            r_modDout <= !w_curPulse;
                        end else if (!w_byteEnd) begin
                            r_symCnt  <= r_symCnt + 2'd1;
                            r_shift   <= {2'b00, r_shift[7:2]};
                            r_modDout <= !w_nextSymPulse;
                        end else if (r_curLast) begin
                            r_state   <= EOF;
                            r_modDout <= !EOF_PAT[3];
                        end else if (r_holdFull || w_accept) begin
                            r_shift    <= w_loadByte;
                            r_curLast  <= w_loadLast;
                            r_holdFull <= 1'b0;
                            r_symCnt   <= '0;
                            r_modDout  <= !w_loadPulse;
                        end else begin
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                            r_modDout  <= 1'b1;
                            r_underrun <= 1'b1;
                        end
                    end
                end
                EOF: begin
                    if (w_tick) begin
                        if (w_patEnd) begin
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                            r_modDout  <= 1'b1;
                            r_lastSeen <= 1'b0;
                        end else begin
                            r_modDout <= !EOF_PAT[2'd3 - w_nextSlot[1:0]];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_accept && !w_bypass) begin
                r_hold     <= bus.tx_data;
                r_holdLast <= bus.tx_last;
                r_holdFull <= 1'b1;
            end
            if (w_accept && bus.tx_last) begin
                r_lastSeen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iso15693_tx_seq.sv
// Scoreboard bench for iso15693_tx_seq: expected pulse offsets are queued when a frame is driven.
// Optional build macro: ISO15693_1OF256_EN (adds the 1-of-256 scenario).
module tb_iso15693_tx_seq;

    localparam int HS = 128;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   frameStart = 0;
    int   expQ[$];
    bit   inPulse = 1'b0;
    int   pulseStart = 0;

    always #5 clk = ~clk;

    iso15693_tx_seq_if bus();

    iso15693_tx_seq #(.HALF_SLOT(HS), .CNT_W(7)) dut (
        .ck_1356meg (clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each falling edge of mod_dout pops the next expected pulse offset
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            inPulse = 1'b0;
        end else if (bus.mod_dout === 1'b0 && !inPulse) begin
            inPulse    = 1'b1;
            pulseStart = cyc;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse offset=%0d required none", cyc - frameStart);
            end else begin
                int e;
                e = expQ.pop_front();
                if ((cyc - frameStart) !== e) begin
                    errors++;
                    $display("[TB] FAIL pulse_offset actual=%0d required=%0d", cyc - frameStart, e);
                end
            end
        end else if (bus.mod_dout === 1'b1 && inPulse) begin
            inPulse = 1'b0;
            checks++;
            if ((cyc - pulseStart) !== HS) begin
                errors++;
                $display("[TB] FAIL pulse_width actual=%0d required=%0d", cyc - pulseStart, HS);
            end
        end
    end

    function automatic void pushSof();
        expQ.push_back(0);
        expQ.push_back(5 * HS);
    endfunction

    function automatic void pushByte(input int idx, input logic [7:0] b);
        for (int j = 0; j < 4; j++) begin
            int sym;
            sym = int'((b >> (2 * j)) & 8'd3);
            expQ.push_back(1024 + idx * 4096 + j * 1024 + (2 * sym + 1) * HS);
        end
    endfunction

    function automatic void pushEof(input int n);
        expQ.push_back(1024 + n * 4096 + 2 * HS);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic sendByte(input logic [7:0] d, input logic l, input bit first);
        int waitCnt;
        bit sampled;
        waitCnt = 0;
        bus.tx_data  = d;
        bus.tx_last  = l;
        bus.tx_valid = 1'b1;
        do begin
            sampled = bus.tx_ready;
            @(posedge clk);
            waitCnt++;
        end while (!sampled && waitCnt < 3000);
        if (first && sampled) frameStart = cyc + 1;
        checks++;
        if (!sampled) begin
            errors++;
            $display("[TB] FAIL accept_timeout actual=%0d required=accepted", waitCnt);
        end
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic waitOffset(input int off);
        while ((cyc - frameStart) < off) @(negedge clk);
    endtask

    task automatic waitIdle(output int off);
        int guard;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 80000) begin
            @(negedge clk);
            guard++;
        end
        off = cyc - frameStart;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.tx_last  = 1'b0;
`ifdef ISO15693_1OF256_EN
        bus.mode256  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.mod_dout !== 1'b1) begin errors++; $display("[TB] FAIL reset_mod_dout actual=%b required=1", bus.mod_dout); end
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy actual=%b required=0", bus.busy); end
        if (bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_ready actual=%b required=1", bus.tx_ready); end
        if (bus.underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun actual=%b required=0", bus.underrun); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single(input logic [7:0] b);
        int off;
        pushSof();
        pushByte(0, b);
        pushEof(1);
        sendByte(b, 1'b1, 1'b1);
        checks += 2;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_start actual=%b required=1", bus.busy); end
        if (bus.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_start actual=%b required=0", bus.tx_ready); end
        waitIdle(off);
        checks += 3;
        if (off !== 5632) begin errors++; $display("[TB] FAIL single_busy_fall actual=%0d required=5632", off); end
        if (bus.mod_dout !== 1'b1) begin errors++; $display("[TB] FAIL single_mod_end actual=%b required=1", bus.mod_dout); end
        if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL single_missing_pulses actual=%0d required=0", expQ.size()); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int off;
        pushSof();
        pushByte(0, 8'h12);
        pushByte(1, 8'h34);
        pushEof(2);
        sendByte(8'h12, 1'b0, 1'b1);
        checks++;
        if (bus.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_holdfull actual=%b required=0", bus.tx_ready); end
        waitOffset(1100);
        checks++;
        if (bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_free actual=%b required=1", bus.tx_ready); end
        sendByte(8'h34, 1'b1, 1'b0);
        checks++;
        if (bus.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_second actual=%b required=0", bus.tx_ready); end
        waitOffset(6000);
        checks += 2;
        if (bus.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_after_last actual=%b required=0", bus.tx_ready); end
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy_mid actual=%b required=1", bus.busy); end
        waitIdle(off);
        checks += 3;
        if (off !== 9728) begin errors++; $display("[TB] FAIL b2b_frame_len actual=%0d required=9728", off); end
        if (bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_idle actual=%b required=1", bus.tx_ready); end
        if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL b2b_missing_pulses actual=%0d required=0", expQ.size()); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_underrun();
        int off;
        pushSof();
        pushByte(0, 8'h5A);
        sendByte(8'h5A, 1'b0, 1'b1);
        waitOffset(5119);
        checks += 2;
        if (bus.underrun !== 1'b0) begin errors++; $display("[TB] FAIL underrun_early actual=%b required=0", bus.underrun); end
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL underrun_busy_before actual=%b required=1", bus.busy); end
        @(negedge clk);
        checks += 4;
        if (bus.underrun !== 1'b1) begin errors++; $display("[TB] FAIL underrun_pulse actual=%b required=1", bus.underrun); end
        if (bus.mod_dout !== 1'b1) begin errors++; $display("[TB] FAIL underrun_mod actual=%b required=1", bus.mod_dout); end
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL underrun_busy actual=%b required=0", bus.busy); end
        if (bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL underrun_ready actual=%b required=1", bus.tx_ready); end
        @(negedge clk);
        checks++;
        if (bus.underrun !== 1'b0) begin errors++; $display("[TB] FAIL underrun_one_cycle actual=%b required=0", bus.underrun); end
        repeat (700) @(negedge clk);
        checks++;
        if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL underrun_missing_pulses actual=%0d required=0", expQ.size()); end
        pushSof();
        pushByte(0, 8'h0F);
        pushEof(1);
        sendByte(8'h0F, 1'b1, 1'b1);
        waitIdle(off);
        checks += 2;
        if (off !== 5632) begin errors++; $display("[TB] FAIL underrun_next_frame actual=%0d required=5632", off); end
        if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL underrun_next_pulses actual=%0d required=0", expQ.size()); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        pushSof();
        pushByte(0, 8'h00);
        pushEof(1);
        sendByte(8'h00, 1'b1, 1'b1);
        waitOffset(1152 + 10);
        checks++;
        if (bus.mod_dout !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pre_mod actual=%b required=0", bus.mod_dout); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.mod_dout !== 1'b1) begin errors++; $display("[TB] FAIL midreset_mod actual=%b required=1", bus.mod_dout); end
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy actual=%b required=0", bus.busy); end
        if (bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready actual=%b required=1", bus.tx_ready); end
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks += 2;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_resume actual=%b required=0", bus.busy); end
        if (bus.mod_dout !== 1'b1) begin errors++; $display("[TB] FAIL midreset_mod_after actual=%b required=1", bus.mod_dout); end
    endtask

`ifdef ISO15693_1OF256_EN
    task automatic test_mode256();
        int off;
        bus.mode256 = 1'b1;
        expQ.push_back(0);
        expQ.push_back(7 * HS);
        expQ.push_back(1024 + 5 * HS);
        expQ.push_back(1024 + 65536 + 2 * HS);
        sendByte(8'h02, 1'b1, 1'b1);
        bus.mode256 = 1'b0;
        waitIdle(off);
        checks += 2;
        if (off !== 1024 + 65536 + 512) begin errors++; $display("[TB] FAIL m256_frame_len actual=%0d required=%0d", off, 1024 + 65536 + 512); end
        if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL m256_missing_pulses actual=%0d required=0", expQ.size()); end
        repeat (10) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single(8'h00);
        test_single(8'hE4);
        test_back_to_back();
        test_underrun();
        test_reset_mid_frame();
`ifdef ISO15693_1OF256_EN
        test_mode256();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
